wb_write_arbiter: RTL and testbench

- Write-side initiator for the CPU register file: the single owner of RegWrite / Write_register / Write_data.
- Merges two result producers:
  - the in-order pipeline writeback stage, which is fixed-latency and never back-pressured;
  - the auxiliary long-latency port (multiply/divide unit, later the load-miss path), which uses a valid/ready handshake and a 2-entry buffer.
- Also reports register-pending hazards to the ID stage, so readers never see stale data.

---
 rtl/wb_write_arbiter_pkg.sv | 25 ++
 rtl/wb_aux_fifo.sv | 62 ++++++
 rtl/wb_write_arbiter.sv | 115 +++++++++++
 tb/tb_wb_write_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_write_arbiter_pkg.sv
// Shared types and helpers for the register-file write arbiter.
// Buffer entries and output requests share one struct.
package wb_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  function automatic logic rd_hit(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rt,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] tgt
  );
    return (rs != REG_ZERO && rs == tgt) ||
           (rt != REG_ZERO && rt == tgt) ||
           (rd != REG_ZERO && rd == tgt);
  endfunction

endpackage

// File: rtl/wb_aux_fifo.sv
// Small sync FIFO for auxiliary results.
// Exposes per-entry rd/valid for hazard detection.
import wb_write_arbiter_pkg::*;

module wb_aux_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  wb_req_t                          wr,
  input  logic                             pop,
  output logic                             full,
  output logic                             empty,
  output wb_req_t                          head,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd,
  output logic [DEPTH-1:0]                 ent_valid
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic [DEPTH-1:0] vld;
  wb_req_t          mem [DEPTH];

  assign full  = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
  assign empty = (wp == rp);
  assign head  = mem[rp[AW-1:0]];
  assign ent_valid = vld;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_rd[i] = mem[i].rd;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp[AW-1:0]] <= wr;
    end
  end

  // Push and pop never target the same slot: push needs !full, pop needs !empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      vld <= '0;
    end else begin
      if (push) begin
        vld[wp[AW-1:0]] <= 1'b1;
        wp <= wp + 1'b1;
      end
      if (pop) begin
        vld[rp[AW-1:0]] <= 1'b0;
        rp <= rp + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write arbiter: pipeline writeback beats buffered aux results.
// Also drives ID hazards and a starvation stall request.
import wb_write_arbiter_pkg::*;

module wb_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [DATA_W-1:0]     pipe_data,
  input  logic                  aux_valid,
  output logic                  aux_ready,
  input  logic [REG_ADDR_W-1:0] aux_rd,
  input  logic [DATA_W-1:0]     aux_data,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  output logic                  hazard,
  output logic                  stall_req,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] Write_register,
  output logic [DATA_W-1:0]     Write_data
);

  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic    full;
  logic    empty;
  logic    hs;
  logic    push;
  logic    pop;
  logic    pipe_eff;
  wb_req_t head;
  wb_req_t wr;

  logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;
  logic [DEPTH-1:0]                 ent_valid;
  logic [AGE_W-1:0]                 age;
  logic [AGE_W-1:0]                 age_nxt;

  assign aux_ready = !full && !reset;
  assign hs        = aux_valid && aux_ready;
  assign push      = hs && (aux_rd != REG_ZERO);
  assign pipe_eff  = pipe_we && (pipe_rd != REG_ZERO);
  assign pop       = !pipe_eff && !empty;
  assign wr        = '{rd: aux_rd, data: aux_data};

  wb_aux_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .wr        (wr),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head),
    .ent_rd    (ent_rd),
    .ent_valid (ent_valid)
  );

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && rd_hit(id_rs, id_rt, id_rd, ent_rd[i])) begin
        hazard = 1'b1;
      end
    end
    if (hs && rd_hit(id_rs, id_rt, id_rd, aux_rd)) begin
      hazard = 1'b1;
    end
  end

  always_comb begin
    age_nxt = age;
    if (empty || pop) begin
      age_nxt = '0;
    end else if (pipe_eff && age != AGE_MAX) begin
      age_nxt = age + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWrite       <= 1'b0;
      Write_register <= '0;
      Write_data     <= '0;
      age            <= '0;
      stall_req      <= 1'b0;
    end else begin
      age <= age_nxt;
      // Sticky until the blocked head finally drains.
      if (pop) begin
        stall_req <= 1'b0;
      end else if (age_nxt == AGE_MAX || (full && aux_valid)) begin
        stall_req <= 1'b1;
      end
      if (pipe_eff) begin
        RegWrite       <= 1'b1;
        Write_register <= pipe_rd;
        Write_data     <= pipe_data;
      end else if (pop) begin
        RegWrite       <= 1'b1;
        Write_register <= head.rd;
        Write_data     <= head.data;
      end else begin
        RegWrite <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter.
// Outputs sampled 1ns after posedge; inputs change at the same point.
`timescale 1ns/1ps

module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_rd;
  logic [31:0] aux_data;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic        hazard;
  logic        stall_req;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .pipe_we        (pipe_we),
    .pipe_rd        (pipe_rd),
    .pipe_data      (pipe_data),
    .aux_valid      (aux_valid),
    .aux_ready      (aux_ready),
    .aux_rd         (aux_rd),
    .aux_data       (aux_data),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rd          (id_rd),
    .hazard         (hazard),
    .stall_req      (stall_req),
    .RegWrite       (RegWrite),
    .Write_register (Write_register),
    .Write_data     (Write_data)
  );

  task automatic fail(
    input string       tag,
    input logic [31:0] o,
    input logic [31:0] e
  );
    n_err++;
    $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    pipe_we = 0; pipe_rd = 0; pipe_data = 0;
    aux_valid = 0; aux_rd = 0; aux_data = 0;
    id_rs = 0; id_rt = 0; id_rd = 0;
    #1;
    n_cmp++;
    if (RegWrite !== 1'b0)
      fail("rst_regwrite", RegWrite, 0);
    n_cmp++;
    if (Write_register !== 5'd0)
      fail("rst_wreg", Write_register, 0);
    n_cmp++;
    if (Write_data !== 32'd0)
      fail("rst_wdata", Write_data, 0);
    n_cmp++;
    if (stall_req !== 1'b0)
      fail("rst_stall", stall_req, 0);
    n_cmp++;
    if (aux_ready !== 1'b0)
      fail("rst_ready", aux_ready, 0);
    tick(); tick();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (aux_ready !== 1'b1)
      fail("rel_ready", aux_ready, 1);

    pipe_we = 1; pipe_rd = 5; pipe_data = 32'h1234;
    tick();
    n_cmp++;
    if (RegWrite !== 1'b1)
      fail("p_we", RegWrite, 1);
    n_cmp++;
    if (Write_register !== 5'd5)
      fail("p_reg", Write_register, 5);
    n_cmp++;
    if (Write_data !== 32'h1234)
      fail("p_data", Write_data, 32'h1234);
    pipe_we = 0;
    tick();
    n_cmp++;
    if (RegWrite !== 1'b0)
      fail("p_idle_we", RegWrite, 0);
    n_cmp++;
    if (Write_register !== 5'd5)
      fail("p_idle_hold", Write_register, 5);

    aux_valid = 1; aux_rd = 7; aux_data = 32'hAAAA; id_rs = 7;
    #1;
    n_cmp++;
    if (hazard !== 1'b1)
      fail("a_hz_hs", hazard, 1);
    tick();
    aux_valid = 0;
    #1;
    n_cmp++;
    if (RegWrite !== 1'b0)
      fail("a_wait_we", RegWrite, 0);
    n_cmp++;
    if (hazard !== 1'b1)
      fail("a_hz_buf", hazard, 1);
    tick();
    n_cmp++;
    if (RegWrite !== 1'b1)
      fail("a_issue_we", RegWrite, 1);
    n_cmp++;
    if (Write_register !== 5'd7)
      fail("a_issue_reg", Write_register, 7);
    n_cmp++;
    if (Write_data !== 32'hAAAA)
      fail("a_issue_data", Write_data, 32'hAAAA);
    n_cmp++;
    if (hazard !== 1'b0)
      fail("a_hz_clear", hazard, 0);
    id_rs = 0;

    pipe_we = 1; pipe_rd = 3; pipe_data = 32'h3333;
    aux_valid = 1; aux_rd = 9; aux_data = 32'h9999;
    tick();
    aux_valid = 0;
    for (int i = 0; i < 7; i++) tick();
    n_cmp++;
    if (stall_req !== 1'b0)
      fail("s_stall_lo", stall_req, 0);
    tick();
    n_cmp++;
    if (stall_req !== 1'b1)
      fail("s_stall_hi", stall_req, 1);
    n_cmp++;
    if (Write_register !== 5'd3)
      fail("s_blocked_reg", Write_register, 3);
    pipe_we = 0;
    tick();
    n_cmp++;
    if (RegWrite !== 1'b1)
      fail("s_drain_we", RegWrite, 1);
    n_cmp++;
    if (Write_register !== 5'd9)
      fail("s_drain_reg", Write_register, 9);
    n_cmp++;
    if (Write_data !== 32'h9999)
      fail("s_drain_data", Write_data, 32'h9999);
    n_cmp++;
    if (stall_req !== 1'b0)
      fail("s_stall_clr", stall_req, 0);

    pipe_we = 1; pipe_rd = 3;
    aux_valid = 1; aux_rd = 10; aux_data = 32'h10;
    tick();
    aux_rd = 11; aux_data = 32'h11;
    tick();
    n_cmp++;
    if (aux_ready !== 1'b0)
      fail("f_ready_lo", aux_ready, 0);
    n_cmp++;
    if (stall_req !== 1'b0)
      fail("f_stall_lo", stall_req, 0);
    aux_rd = 12; aux_data = 32'h12; id_rd = 10;
    #1;
    n_cmp++;
    if (hazard !== 1'b1)
      fail("f_hz_rd", hazard, 1);
    tick();
    n_cmp++;
    if (stall_req !== 1'b1)
      fail("f_stall_hi", stall_req, 1);
    pipe_we = 0; aux_valid = 0; id_rd = 0;
    tick();
    n_cmp++;
    if (Write_register !== 5'd10)
      fail("f_pop1_reg", Write_register, 10);
    n_cmp++;
    if (Write_data !== 32'h10)
      fail("f_pop1_data", Write_data, 32'h10);
    n_cmp++;
    if (aux_ready !== 1'b1)
      fail("f_ready_hi", aux_ready, 1);
    n_cmp++;
    if (stall_req !== 1'b0)
      fail("f_stall_clr", stall_req, 0);
    tick();
    n_cmp++;
    if (RegWrite !== 1'b1)
      fail("f_pop2_we", RegWrite, 1);
    n_cmp++;
    if (Write_register !== 5'd11)
      fail("f_pop2_reg", Write_register, 11);
    tick();
    n_cmp++;
    if (RegWrite !== 1'b0)
      fail("f_idle_we", RegWrite, 0);

    pipe_we = 1; pipe_rd = 3; pipe_data = 32'h3;
    aux_valid = 1; aux_rd = 13; aux_data = 32'h13;
    tick();
    pipe_rd = 0; aux_rd = 0; aux_data = 32'hDEAD;
    tick();
    n_cmp++;
    if (RegWrite !== 1'b1)
      fail("z_drain_we", RegWrite, 1);
    n_cmp++;
    if (Write_register !== 5'd13)
      fail("z_drain_reg", Write_register, 13);
    n_cmp++;
    if (Write_data !== 32'h13)
      fail("z_drain_data", Write_data, 32'h13);
    pipe_we = 0; aux_valid = 0;
    tick();
    n_cmp++;
    if (RegWrite !== 1'b0)
      fail("z_no_enq_we", RegWrite, 0);

    pipe_we = 1; pipe_rd = 3; pipe_data = 32'h3;
    aux_valid = 1; aux_rd = 20; aux_data = 32'h20;
    tick();
    aux_rd = 21; aux_data = 32'h21;
    tick();
    aux_valid = 0; id_rd = 20;
    #1;
    n_cmp++;
    if (hazard !== 1'b1)
      fail("r_pre_hz", hazard, 1);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (RegWrite !== 1'b0)
      fail("r_we", RegWrite, 0);
    n_cmp++;
    if (Write_register !== 5'd0)
      fail("r_wreg", Write_register, 0);
    n_cmp++;
    if (hazard !== 1'b0)
      fail("r_hz", hazard, 0);
    n_cmp++;
    if (aux_ready !== 1'b0)
      fail("r_ready", aux_ready, 0);
    pipe_we = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (aux_ready !== 1'b1)
      fail("r_rel_ready", aux_ready, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (RegWrite !== 1'b0)
        fail("r_no_stale", RegWrite, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
